// File: rtl/program_loader.sv
// program_loader
//   Byte-stream program loader driving the CPU program-download port.
//   A frame is: sync 0xA5, START_L, START_H, CNT_L, CNT_H, then CNT x (LO, HI)
//   instruction bytes, optionally followed by a checksum byte.
//   Each accepted HI byte places one instruction on program_in at
//   instruction_index = start + k and holds download_program high. After the
//   last word the CPU is released and done pulses for one cycle.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     defined   : the frame ends with a CSUM byte equal to the XOR of every
//                 byte after sync. A mismatch sets the sticky error flag,
//                 suppresses done and keeps the CPU held in download mode.
//     undefined : no CSUM byte; error is tied low.
//
// Ports
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   rx_data, rx_valid  : incoming frame byte and its valid
//   rx_ready           : byte accepted when rx_valid && rx_ready at clk edge
//   download_program   : CPU held in download mode, program bus live
//   instruction_index  : target instruction slot (INDEX_W bits)
//   program_in         : instruction halfword
//   busy               : frame in progress
//   done               : one-cycle pulse, frame loaded and CPU released
//   error              : sticky checksum-mismatch flag
module program_loader #(
  parameter int unsigned INDEX_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               download_program,
  output logic [INDEX_W-1:0] instruction_index,
  output logic [15:0]        program_in,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_IDX_L,
    S_IDX_H,
    S_CNT_L,
    S_CNT_H,
    S_DAT_L,
    S_DAT_H,
    S_FINISH
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CSUM
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          start_q, start_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          k_q, k_d;
  logic [7:0]           lo_q, lo_d;
  logic                 dp_q, dp_d;
  logic [INDEX_W-1:0]   idx_q, idx_d;
  logic [15:0]          pin_q, pin_d;
  logic                 done_q, done_d;
  logic                 accept;
  state_t               tail_state;
  logic [15:0]          cnt_new;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
  logic                 error_q, error_d;
`endif

  assign rx_ready = (state_q != S_FINISH);
  assign accept   = rx_valid && rx_ready;
  assign cnt_new  = {rx_data, cnt_q[7:0]};

`ifdef LOADER_CHECKSUM_EN
  assign tail_state = S_CSUM;
`else
  assign tail_state = S_FINISH;
`endif

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    lo_d    = lo_q;
    dp_d    = dp_q;
    idx_d   = idx_q;
    pin_d   = pin_q;
    done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    error_d = error_q;
`endif

    if (state_q == S_FINISH) begin
      // FINISH never accepts a byte; it only releases the CPU.
      dp_d    = 1'b0;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end else if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == 8'hA5) begin
            state_d = S_IDX_L;
`ifdef LOADER_CHECKSUM_EN
            error_d = 1'b0;
            csum_d  = '0;
`endif
          end
        end
        S_IDX_L: begin
          start_d[7:0] = rx_data;
          state_d      = S_IDX_H;
        end
        S_IDX_H: begin
          start_d[15:8] = rx_data;
          state_d       = S_CNT_L;
        end
        S_CNT_L: begin
          cnt_d[7:0] = rx_data;
          state_d    = S_CNT_H;
        end
        S_CNT_H: begin
          cnt_d   = cnt_new;
          k_d     = '0;
          state_d = (cnt_new == '0) ? tail_state : S_DAT_L;
        end
        S_DAT_L: begin
          lo_d    = rx_data;
          state_d = S_DAT_H;
        end
        S_DAT_H: begin
          pin_d = {rx_data, lo_q};
          // start <= 0xFFFF and k <= 0xFFFE, so no wrap for INDEX_W >= 17
          idx_d = INDEX_W'(start_q) + INDEX_W'(k_q);
          dp_d  = 1'b1;
          if (16'(k_q + 16'd1) == cnt_q) begin
            state_d = tail_state;
          end else begin
            k_d     = 16'(k_q + 16'd1);
            state_d = S_DAT_L;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_data == csum_q) begin
            state_d = S_FINISH;
          end else begin
            // Mismatch leaves download_program as is: the CPU stays held.
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase

`ifdef LOADER_CHECKSUM_EN
      if (state_q != S_IDLE && state_q != S_CSUM) begin
        csum_d = csum_q ^ rx_data;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      lo_q    <= '0;
      dp_q    <= 1'b0;
      idx_q   <= '0;
      pin_q   <= '0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      lo_q    <= lo_d;
      dp_q    <= dp_d;
      idx_q   <= idx_d;
      pin_q   <= pin_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      error_q <= error_d;
`endif
    end
  end

  assign download_program  = dp_q;
  assign instruction_index = idx_q;
  assign program_in        = pin_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Randomized self-checking bench for program_loader. Frames are built from
//   (start, word list) and the expected CPU writes are simply start+k -> word[k].
//   A CPU-like monitor samples the bus on the falling edge whenever
//   download_program is high and records each distinct slot written.
module tb_program_loader;

  localparam int unsigned INDEX_W = 32;

  logic               clk;
  logic               rst_n;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               download_program;
  logic [INDEX_W-1:0] instruction_index;
  logic [15:0]        program_in;
  logic               busy;
  logic               done;
  logic               error;

  program_loader #(.INDEX_W(INDEX_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .download_program  (download_program),
    .instruction_index (instruction_index),
    .program_in        (program_in),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: CPU view of the program bus
  logic [31:0] cap_idx[$];
  logic [15:0] cap_w[$];
  int          done_total  = 0;
  logic        prev_dp     = 1'b0;
  logic        prev_done   = 1'b0;
  logic [31:0] last_idx    = '0;
  logic [15:0] last_w      = '0;
  logic        exp_prev_dp = 1'b1;

  always @(negedge clk) begin
    if (download_program === 1'b1) begin
      if (!prev_dp || instruction_index != last_idx) begin
        cap_idx.push_back(instruction_index);
        cap_w.push_back(program_in);
      end else begin
        check_eq("bus_stable", {48'd0, program_in}, {48'd0, last_w});
      end
    end
    if (done === 1'b1) begin
      done_total++;
      check_eq("dp_fall_with_done", {63'd0, download_program}, 64'd0);
      check_eq("dp_before_done", {63'd0, prev_dp}, {63'd0, exp_prev_dp});
      check_eq("done_width", {63'd0, prev_done}, 64'd0);
    end
    prev_dp   = download_program;
    prev_done = done;
    last_idx  = instruction_index;
    last_w    = program_in;
  end

  // Stimulus helpers; drive at posedge+1
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    while (rx_ready !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) check_eq("rx_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  logic [15:0] ew[$];  // words of the frame under test

  task automatic build_frame(input logic [15:0] start, input bit junk,
                             input bit bad_csum, output logic [7:0] fq[$]);
    logic [7:0] cs;
    logic [15:0] n;
    fq.delete();
    n = 16'(ew.size());
    if (junk) begin
      fq.push_back(8'h00);
      fq.push_back(8'hFF);
    end
    fq.push_back(8'hA5);
    fq.push_back(start[7:0]);
    fq.push_back(start[15:8]);
    fq.push_back(n[7:0]);
    fq.push_back(n[15:8]);
    foreach (ew[i]) begin
      fq.push_back(ew[i][7:0]);
      fq.push_back(ew[i][15:8]);
    end
    cs = 8'h00;
    for (int i = (junk ? 3 : 1); i < fq.size(); i++) cs ^= fq[i];
`ifdef LOADER_CHECKSUM_EN
    fq.push_back(bad_csum ? (cs ^ 8'h5A) : cs);
`else
    if (bad_csum) cs = 8'h00;
`endif
  endtask

  task automatic run_frame(input string name, input logic [15:0] start, input int gapmax,
                           input bit junk, input bit bad_csum);
    logic [7:0] fq[$];
    int cap_base, done_base, waited;
    build_frame(start, junk, bad_csum, fq);
    cap_base    = cap_idx.size();
    done_base   = done_total;
    exp_prev_dp = (ew.size() > 0);
    foreach (fq[i]) send_byte(fq[i], $urandom_range(0, gapmax));
    waited = 0;
    while (busy === 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) check_eq({name, "_busy_timeout"}, 64'd0, 64'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq({name, "_nwrites"}, 64'(cap_idx.size() - cap_base), 64'(ew.size()));
    foreach (ew[k]) begin
      if (cap_base + k < cap_idx.size()) begin
        check_eq({name, "_idx"}, {32'd0, cap_idx[cap_base + k]}, 64'(32'(start) + 32'(k)));
        check_eq({name, "_word"}, {48'd0, cap_w[cap_base + k]}, {48'd0, ew[k]});
      end
    end
    check_eq({name, "_done_cnt"}, 64'(done_total - done_base), bad_csum ? 64'd0 : 64'd1);
    check_eq({name, "_error"}, {63'd0, error}, {63'd0, bad_csum});
    check_eq({name, "_dp_final"}, {63'd0, download_program},
             (bad_csum && ew.size() > 0) ? 64'd1 : 64'd0);
    check_eq({name, "_busy_final"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic load_frame_a();
    ew.delete();
    ew.push_back(16'h2005);
    ew.push_back(16'h1FC2);
    ew.push_back(16'hE7FE);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_dp"},   {63'd0, download_program}, 64'd0);
    check_eq({name, "_idx"},  {32'd0, instruction_index}, 64'd0);
    check_eq({name, "_pin"},  {48'd0, program_in}, 64'd0);
    check_eq({name, "_busy"}, {63'd0, busy}, 64'd0);
    check_eq({name, "_done"}, {63'd0, done}, 64'd0);
    check_eq({name, "_err"},  {63'd0, error}, 64'd0);
  endtask

  initial begin
    logic [7:0] fq[$];
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rx_ready_after_reset", {63'd0, rx_ready}, 64'd1);

    // Reference frame, back to back
    load_frame_a();
    run_frame("frameA", 16'h000A, 0, 1'b0, 1'b0);
    // Same frame with random rx_valid gaps
    run_frame("frameA_gaps", 16'h000A, 3, 1'b0, 1'b0);
    // Leading junk ahead of sync
    run_frame("frameA_junk", 16'h000A, 0, 1'b1, 1'b0);
    // Empty frame
    ew.delete();
    run_frame("empty", 16'h000A, 1, 1'b0, 1'b0);
    // Maximum start index: reaches past 16 bits
    ew.delete();
    for (int i = 0; i < 3; i++) ew.push_back(16'($urandom));
    run_frame("max_start", 16'hFFFF, 2, 1'b0, 1'b0);
    // Random frames
    for (int f = 0; f < 6; f++) begin
      ew.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) ew.push_back(16'($urandom));
      run_frame("rand", 16'($urandom), 3, 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    load_frame_a();
    run_frame("bad_csum", 16'h000A, 0, 1'b0, 1'b1);
    run_frame("after_bad", 16'h000A, 1, 1'b0, 1'b0);
`endif

    // Reset mid-frame, right after the second word
    load_frame_a();
    build_frame(16'h000A, 1'b0, 1'b0, fq);
    for (int i = 0; i < 9; i++) send_byte(fq[i], 0);
    check_eq("mid_dp_before_reset", {63'd0, download_program}, 64'd1);
    check_eq("mid_idx_before_reset", {32'd0, instruction_index}, 64'd11);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("after_reset", 16'h000A, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
